// File: rtl/array20_pkg.sv
// array20_pkg: shared constants and grant encoding for the array_20 RW front-end
package array20_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 2112;
  localparam int MASK_W = 16;
  localparam int LANE_W = DATA_W / MASK_W;
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;
endpackage

// File: rtl/array_20_resp_fifo.sv
// array_20_resp_fifo: circular response buffer with registered head entry
module array_20_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] dout
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop) rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // credit in the parent makes this unreachable; a hit means the credit math broke
  always_ff @(posedge clk)
    if (rst_n) assert (!(push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/array_20_rw_ctrl.sv
// array_20_rw_ctrl: RW-port arbiter + credited read buffer for array_20_ext; ARRAY20_RW_CTRL_PERF_EN adds perf counters
module array_20_rw_ctrl import array20_pkg::*; #(
  parameter int OUT_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [MASK_W-1:0] w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rq_valid,
  output logic              rq_ready,
  input  logic [ADDR_W-1:0] rq_addr,
  output logic              rs_valid,
  input  logic              rs_ready,
  output logic [DATA_W-1:0] rs_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
`ifdef ARRAY20_RW_CTRL_PERF_EN
  output logic [31:0]       perf_rd,
  output logic [31:0]       perf_wr,
  output logic [31:0]       perf_stall,
`endif
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam int CW = $clog2(OUT_DEPTH + 1);
  gnt_e gnt;
  logic prio_rd, inflight, pop, rd_ok;
  logic [CW-1:0] count;
  logic [CW:0] credit;
  logic [ADDR_W-1:0] addr_q;
  logic [MASK_W-1:0] mask_q;
  logic [DATA_W-1:0] data_q;
  // a read is only issued if a buffer slot is guaranteed for its data
  always_comb begin
    rs_valid = count != '0;
    pop = rs_valid & rs_ready;
    credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    rd_ok = credit < (CW+1)'(OUT_DEPTH);
    gnt = !reset_n ? GNT_NONE
        : (rq_valid && rd_ok && (!w_valid || prio_rd)) ? GNT_RD
        : w_valid ? GNT_WR : GNT_NONE;
    w_ready = gnt == GNT_WR;
    rq_ready = gnt == GNT_RD;
    sram_en = gnt != GNT_NONE;
    sram_wmode = w_ready;
    sram_addr = w_ready ? w_addr : rq_ready ? rq_addr : addr_q;
    sram_wmask = w_ready ? w_mask : mask_q;
    sram_wdata = w_ready ? w_data : data_q;
  end
  // idle port replays the last driven values so the macro inputs stay quiet
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      prio_rd <= 1'b0;
      inflight <= 1'b0;
      addr_q <= '0;
      mask_q <= '0;
      data_q <= '0;
    end else begin
      inflight <= rq_ready;
      if (w_valid && rq_valid && rd_ok) prio_rd <= !prio_rd;
      if (sram_en) addr_q <= sram_addr;
      if (w_ready) begin
        mask_q <= w_mask;
        data_q <= w_data;
      end
    end
  array_20_resp_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_W), .CW(CW)) u_fifo (
    .clk(clock),
    .rst_n(reset_n),
    .push(inflight),
    .din(sram_rdata),
    .pop(pop),
    .count(count),
    .dout(rs_data)
  );
`ifdef ARRAY20_RW_CTRL_PERF_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      perf_rd <= '0;
      perf_wr <= '0;
      perf_stall <= '0;
    end else begin
      if (rq_ready && !(&perf_rd)) perf_rd <= perf_rd + 32'd1;
      if (w_ready && !(&perf_wr)) perf_wr <= perf_wr + 32'd1;
      if (rq_valid && !rq_ready && !(&perf_stall)) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_array_20_rw_ctrl.sv
// tb_array_20_rw_ctrl: directed vectors and corner sequences against a behavioural array_20_ext model
module tb_array_20_rw_ctrl;
  import array20_pkg::*;
  logic clk = 1'b0, reset_n;
  logic w_valid, w_ready, rq_valid, rq_ready, rs_valid, rs_ready, sram_en, sram_wmode;
  logic [ADDR_W-1:0] w_addr, rq_addr, sram_addr, ra;
  logic [MASK_W-1:0] w_mask, sram_wmask;
  logic [DATA_W-1:0] w_data, rs_data, sram_wdata, sram_rdata;
  logic [DATA_W-1:0] mem [1024];
`ifdef ARRAY20_RW_CTRL_PERF_EN
  logic [31:0] perf_rd, perf_wr, perf_stall;
`endif
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  array_20_rw_ctrl dut (
    .clock(clk), .reset_n(reset_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_mask(w_mask), .w_data(w_data),
    .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_addr(rq_addr),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_data(rs_data),
    .sram_addr(sram_addr), .sram_en(sram_en), .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata),
`ifdef ARRAY20_RW_CTRL_PERF_EN
    .perf_rd(perf_rd), .perf_wr(perf_wr), .perf_stall(perf_stall),
`endif
    .sram_rdata(sram_rdata)
  );
  // macro model: masked lane writes, registered read address
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    ra = '0;
  end
  always @(posedge clk) begin
    logic [DATA_W-1:0] t;
    if (sram_en) begin
      if (sram_wmode) begin
        t = mem[sram_addr];
        for (int l = 0; l < MASK_W; l++)
          if (sram_wmask[l]) t[l*LANE_W +: LANE_W] = sram_wdata[l*LANE_W +: LANE_W];
        mem[sram_addr] <= t;
      end else ra <= sram_addr;
    end
  end
  assign sram_rdata = mem[ra];
  function automatic logic [DATA_W-1:0] pat(int p);
    logic [DATA_W-1:0] d;
    d = '1;
    if (p == 0) d = '0;
    else if (p == 2) d[131:0] = '0;
    else if (p == 3) for (int l = 0; l < 16; l++) d[l*132 +: 132] = (l % 2 == 1) ? '1 : '0;
    else if (p == 4) d[2111:1980] = '0;
    else if (p >= 16) d = {66{(32'(p) * 32'h01010101) ^ 32'h5A5A0000}};
    return d;
  endfunction
  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic chkd(string n, logic [DATA_W-1:0] got, logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h", n,
               got[DATA_W-1 -: 64], got[63:0], exp[DATA_W-1 -: 64], exp[63:0]);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr1(logic [9:0] a, logic [15:0] m, logic [DATA_W-1:0] d);
    w_valid = 1'b1; w_addr = a; w_mask = m; w_data = d;
    @(negedge clk);
    chk("setup_w_ready", w_ready, 1);
    tick;
    w_valid = 1'b0;
  endtask
  typedef struct {
    bit wr;
    logic [9:0] addr;
    logic [15:0] mask;
    int p;
  } vec_t;
  vec_t vt[9];
  logic [9:0] bp_a[4];
  int k, r;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    vt[0] = '{1'b1, 10'h005, 16'hFFFF, 1};
    vt[1] = '{1'b0, 10'h005, 16'h0000, 1};
    vt[2] = '{1'b1, 10'h3FF, 16'hFFFF, 1};
    vt[3] = '{1'b1, 10'h3FF, 16'h0001, 0};
    vt[4] = '{1'b0, 10'h3FF, 16'h0000, 2};
    vt[5] = '{1'b1, 10'h000, 16'hAAAA, 1};
    vt[6] = '{1'b0, 10'h000, 16'h0000, 3};
    vt[7] = '{1'b1, 10'h005, 16'h8000, 0};
    vt[8] = '{1'b0, 10'h005, 16'h0000, 4};
    bp_a = '{10'h101, 10'h102, 10'h103, 10'h104};
    reset_n = 1'b0; w_valid = 1'b1; rq_valid = 1'b1; rs_ready = 1'b1;
    w_addr = 10'h001; w_mask = '1; w_data = '0; rq_addr = 10'h002;
    @(negedge clk);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_rq_ready", rq_ready, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_rs_valid", rs_valid, 0);
    tick;
    reset_n = 1'b1; w_valid = 1'b0; rq_valid = 1'b0;
    tick;
    for (int i = 0; i < 9; i++) begin
      if (vt[i].wr) begin
        w_valid = 1'b1; w_addr = vt[i].addr; w_mask = vt[i].mask; w_data = pat(vt[i].p);
      end else begin
        rq_valid = 1'b1; rq_addr = vt[i].addr;
      end
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), vt[i].wr ? w_ready : rq_ready, 1);
      chk($sformatf("v%0d_other", i), vt[i].wr ? rq_ready : w_ready, 0);
      chk($sformatf("v%0d_en", i), sram_en, 1);
      chk($sformatf("v%0d_wmode", i), sram_wmode, 64'(vt[i].wr));
      chk($sformatf("v%0d_addr", i), sram_addr, vt[i].addr);
      if (vt[i].wr) chk($sformatf("v%0d_mask", i), sram_wmask, vt[i].mask);
      tick;
      w_valid = 1'b0; rq_valid = 1'b0; w_addr = ~vt[i].addr; w_mask = ~vt[i].mask; rq_addr = ~vt[i].addr;
      @(negedge clk);
      chk($sformatf("v%0d_idle_en", i), sram_en, 0);
      chk($sformatf("v%0d_idle_addr", i), sram_addr, vt[i].addr);
      if (vt[i].wr) chk($sformatf("v%0d_idle_mask", i), sram_wmask, vt[i].mask);
      else chk($sformatf("v%0d_rsv_t1", i), rs_valid, 0);
      tick;
      if (!vt[i].wr) begin
        @(negedge clk);
        chk($sformatf("v%0d_rsv_t2", i), rs_valid, 1);
        chkd($sformatf("v%0d_rdata", i), rs_data, pat(vt[i].p));
        tick;
      end
    end
    // both channels pending: strict alternation starting with write
    w_addr = 10'h010; w_mask = '1; w_data = pat('h1010); rq_addr = 10'h010;
    for (int c = 0; c < 9; c++) begin
      w_valid = c < 6; rq_valid = c < 6;
      @(negedge clk);
      if (c < 6) begin
        chk($sformatf("alt%0d_w", c), w_ready, 64'(c % 2 == 0));
        chk($sformatf("alt%0d_r", c), rq_ready, 64'(c % 2 == 1));
      end
      chk($sformatf("alt%0d_rsv", c), rs_valid, 64'(c == 3 || c == 5 || c == 7));
      if (rs_valid) chkd($sformatf("alt%0d_data", c), rs_data, pat('h1010));
      tick;
    end
    // backpressure: two reads fit, the rest wait for credit
    for (int i = 0; i < 4; i++) wr1(bp_a[i], '1, pat('h1000 + int'(bp_a[i])));
    rs_ready = 1'b0; k = 0; r = 0;
    for (int c = 0; c < 6; c++) begin
      rq_valid = 1'b1; rq_addr = bp_a[k];
      @(negedge clk);
      chk($sformatf("bp%0d_grant", c), rq_ready, 64'(c < 2));
      if (c >= 3) chkd($sformatf("bp%0d_head", c), rs_data, pat('h1101));
      if (rq_ready) k++;
      tick;
    end
    rs_ready = 1'b1;
    for (int c = 0; c < 30 && r < 4; c++) begin
      rq_valid = k < 4; rq_addr = bp_a[k % 4];
      @(negedge clk);
      if (rs_valid) begin
        chkd($sformatf("bp_resp%0d", r), rs_data, pat('h1000 + int'(bp_a[r])));
        r++;
      end
      if (rq_ready) k++;
      tick;
    end
    rq_valid = 1'b0;
    chk("bp_all_resp", 64'(r), 4);
    // eight back-to-back reads at full rate
    for (int i = 0; i < 8; i++) wr1(10'h200 + 10'(i), '1, pat('h1200 + i));
    for (int c = 0; c < 11; c++) begin
      rq_valid = c < 8; rq_addr = 10'h200 + 10'(c);
      @(negedge clk);
      if (c < 8) chk($sformatf("b2b%0d_grant", c), rq_ready, 1);
      chk($sformatf("b2b%0d_rsv", c), rs_valid, 64'(c >= 2 && c < 10));
      if (rs_valid) chkd($sformatf("b2b%0d_data", c), rs_data, pat('h1200 + c - 2));
      tick;
    end
    // reset one cycle after a read grant, with prio left pointing at read
    w_valid = 1'b1; rq_valid = 1'b1; w_addr = 10'h300; w_data = '0; w_mask = '1; rq_addr = 10'h005;
    @(negedge clk);
    chk("pre_rst_w_first", w_ready, 1);
    tick;
    w_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_read", rq_ready, 1);
    tick;
    rq_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rsv", rs_valid, 0);
    tick;
    tick;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_rsv", c), rs_valid, 0);
      tick;
    end
    w_valid = 1'b1; rq_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_prio_w", w_ready, 1);
    chk("post_rst_prio_r", rq_ready, 0);
    tick;
    w_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_read", rq_ready, 1);
    tick;
    rq_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_t1", rs_valid, 0);
    tick;
    @(negedge clk);
    chk("post_rst_t2", rs_valid, 1);
    chkd("post_rst_data", rs_data, pat(4));
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
